// File: rtl/fetch_queue_stage.sv
// Decoupled fetch stage: BTB-steered PC issue to an in-order variable-latency imem, DEPTH-entry
// prefetch queue to decode. Optional saturating perf counters under FETCH_PERF_CNT_EN.
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] btb_lookup_pc_o,
  input  logic            btb_hit_i,
  input  logic            btb_taken_i,
  input  logic [XLEN-1:0] btb_target_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            if_pred_taken_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_discard_cnt_o,
  output logic [31:0]     perf_stall_cnt_o
`endif
);

  localparam int unsigned     PtrW      = $clog2(DEPTH);
  localparam int unsigned     CntW      = PtrW + 1;
  localparam logic [CntW:0]   DepthLim  = (CntW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

  logic            active_q;
  logic [XLEN-1:0] pc_q, pc_d;

  // Tag FIFO holds {pc, pred} of live (post-redirect) requests only.
  logic [XLEN-1:0] tag_pc_q   [DEPTH];
  logic            tag_pred_q [DEPTH];
  logic [PtrW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [XLEN-1:0] q_pc_q    [DEPTH];
  logic [XLEN-1:0] q_instr_q [DEPTH];
  logic            q_pred_q  [DEPTH];
  logic [PtrW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [CntW-1:0] q_cnt_q, q_cnt_d;

  // out_q counts every request still in flight at the memory, stale ones included, so the
  // credit check also bounds how many discards can ever be pending.
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] disc_q, disc_d;

  logic credit_ok, fire, pred, push, pop;

  assign credit_ok        = ({1'b0, q_cnt_q} + {1'b0, out_q}) < DepthLim;
  assign imem_req_valid_o = active_q && !redirect_valid_i && credit_ok;
  assign fire             = imem_req_valid_o && imem_req_ready_i;
  assign pred             = btb_hit_i && btb_taken_i;
  assign push             = imem_rsp_valid_i && !redirect_valid_i && (disc_q == '0);
  assign pop              = if_valid_o && if_ready_i && !redirect_valid_i;

  assign btb_lookup_pc_o = pc_q;
  assign imem_addr_o     = pc_q;

  assign if_valid_o      = (q_cnt_q != '0);
  assign if_pc_o         = if_valid_o ? q_pc_q[q_rd_q] : '0;
  assign if_instr_o      = if_valid_o ? q_instr_q[q_rd_q] : '0;
  assign if_pred_taken_o = if_valid_o && q_pred_q[q_rd_q];

  always_comb begin
    pc_d     = pc_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    q_wr_d   = q_wr_q;
    q_rd_d   = q_rd_q;
    q_cnt_d  = q_cnt_q;
    disc_d   = disc_q;
    out_d    = out_q + CntW'(fire) - CntW'(imem_rsp_valid_i);
    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i & AlignMask;
      tag_wr_d = '0;
      tag_rd_d = '0;
      q_wr_d   = '0;
      q_rd_d   = '0;
      q_cnt_d  = '0;
      disc_d   = out_d;
    end else begin
      if (fire) begin
        pc_d     = pred ? (btb_target_i & AlignMask) : pc_q + XLEN'(4);
        tag_wr_d = tag_wr_q + PtrW'(1);
      end
      if (push) begin
        tag_rd_d = tag_rd_q + PtrW'(1);
        q_wr_d   = q_wr_q + PtrW'(1);
      end
      if (pop) begin
        q_rd_d = q_rd_q + PtrW'(1);
      end
      q_cnt_d = q_cnt_q + CntW'(push) - CntW'(pop);
      if (imem_rsp_valid_i && (disc_q != '0)) begin
        disc_d = disc_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      pc_q     <= RESET_PC;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      q_wr_q   <= '0;
      q_rd_q   <= '0;
      q_cnt_q  <= '0;
      out_q    <= '0;
      disc_q   <= '0;
    end else begin
      active_q <= 1'b1;
      pc_q     <= pc_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      q_wr_q   <= q_wr_d;
      q_rd_q   <= q_rd_d;
      q_cnt_q  <= q_cnt_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
    end
  end

  // Storage needs no reset: every read is qualified by a pointer/count that is reset.
  always_ff @(posedge clk_i) begin
    if (fire) begin
      tag_pc_q[tag_wr_q]   <= pc_q;
      tag_pred_q[tag_wr_q] <= pred;
    end
    if (push) begin
      q_pc_q[q_wr_q]    <= tag_pc_q[tag_rd_q];
      q_pred_q[q_wr_q]  <= tag_pred_q[tag_rd_q];
      q_instr_q[q_wr_q] <= imem_rsp_data_i;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        drop, stall;
  logic [31:0] perf_fetch_q, perf_discard_q, perf_stall_q;

  assign drop  = imem_rsp_valid_i && (redirect_valid_i || (disc_q != '0));
  assign stall = !redirect_valid_i && !credit_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_q   <= '0;
      perf_discard_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (fire && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (drop && (perf_discard_q != '1)) perf_discard_q <= perf_discard_q + 32'd1;
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o   = perf_fetch_q;
  assign perf_discard_cnt_o = perf_discard_q;
  assign perf_stall_cnt_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: cycle vector table, directed corner sequences and a randomized
// run against an epoch-tagged memory/queue reference model.
module tb_fetch_queue_stage;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] btb_lookup_pc;
  logic        btb_hit, btb_taken;
  logic [31:0] btb_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        if_pred_taken;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_discard_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .btb_lookup_pc_o  (btb_lookup_pc),
    .btb_hit_i        (btb_hit),
    .btb_taken_i      (btb_taken),
    .btb_target_i     (btb_target),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_addr_o      (imem_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .if_pred_taken_o  (if_pred_taken)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o   (perf_fetch_cnt),
    .perf_discard_cnt_o (perf_discard_cnt),
    .perf_stall_cnt_o   (perf_stall_cnt)
`endif
  );

  typedef struct { logic [31:0] pc; bit pred; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] addr; bit pred; int epoch; int due; } pend_t;
  typedef struct {
    bit redirect; logic [31:0] rpc; bit hit; bit taken; logic [31:0] tgt; bit ifr;
    bit e_req; logic [31:0] e_addr; bit e_ifv; logic [31:0] e_ifpc; bit e_pred;
  } vec_t;

  entry_t      mq[$];    // expected decode queue contents
  pend_t       pend[$];  // requests outstanding at the memory model
  logic [31:0] ref_pc;
  bit          active, exp_req_valid, last_fire;
  int          epoch, cyc, n_fire;
  int unsigned ready_pct, rsp_pct, lat_min, lat_max;
  int          n_tests, n_fail;
  vec_t        vt[10];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_cycle(input bit redir, input logic [31:0] rpc, input bit hit,
                             input bit taken, input logic [31:0] tgt, input bit ifr);
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    btb_hit        = hit;
    btb_taken      = taken;
    btb_target     = tgt;
    if_ready       = ifr;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend.size() != 0) begin
      if (pend[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend[0].addr);
      end
    end
    #1;
    exp_req_valid = active && !redir && (mq.size() + pend.size() < DEPTH);
    last_fire     = exp_req_valid && imem_req_ready;
    check("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
    check("imem_addr", imem_addr, ref_pc);
    check("btb_lookup_pc", btb_lookup_pc, ref_pc);
    check("if_valid", 32'(if_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("if_pc", if_pc, mq[0].pc);
      check("if_instr", if_instr, mq[0].instr);
      check("if_pred", 32'(if_pred_taken), 32'(mq[0].pred));
    end else begin
      check("if_pc_empty", if_pc, 32'h0);
      check("if_instr_empty", if_instr, 32'h0);
      check("if_pred_empty", 32'(if_pred_taken), 32'h0);
    end
  endtask

  task automatic commit();
    pend_t  r, p;
    entry_t e;
    bit     rsp, pred;
    @(posedge clk);
    rsp  = imem_rsp_valid;
    pred = btb_hit && btb_taken;
    if (rsp) r = pend.pop_front();
    if (redirect_valid) begin
      mq.delete();
      epoch++;
      ref_pc = redirect_pc & ~32'h3;
    end else begin
      if (mq.size() != 0 && if_ready) e = mq.pop_front();
      if (rsp && r.epoch == epoch) begin
        e.pc    = r.addr;
        e.pred  = r.pred;
        e.instr = instr_of(r.addr);
        mq.push_back(e);
      end
      if (last_fire) begin
        p.addr  = ref_pc;
        p.pred  = pred;
        p.epoch = epoch;
        p.due   = cyc + int'($urandom_range(lat_max, lat_min));
        pend.push_back(p);
        ref_pc = pred ? (btb_target & ~32'h3) : ref_pc + 32'd4;
        n_fire++;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit hit, input bit taken,
                      input logic [31:0] tgt, input bit ifr);
    drive_cycle(redir, rpc, hit, taken, tgt, ifr);
    commit();
  endtask

  task automatic release_reset();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    btb_hit        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    active = 1'b1;
    cyc++;
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_pc", btb_lookup_pc, RESET_PC);
    mq.delete();
    pend.delete();
    ref_pc = RESET_PC;
    active = 1'b0;
    n_fire = 0;
    epoch++;
    release_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] popped[$];
    logic [31:0] first_addr;
    bit          seen, r, h, t, f;
    logic [31:0] rpc;

    n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; n_fire = 0;
    ready_pct = 100; rsp_pct = 100; lat_min = 1; lat_max = 1;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; btb_hit = 1'b0; btb_taken = 1'b0;
    btb_target = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if_ready = 1'b0; ref_pc = RESET_PC; active = 1'b0;
    #2;
    check("reset_req_valid", 32'(imem_req_valid), 32'h0);
    check("reset_if_valid", 32'(if_valid), 32'h0);
    check("reset_pc", btb_lookup_pc, RESET_PC);
    check("reset_if_pc", if_pc, 32'h0);

    // Sequential fetch, BTB hit at 0x8 -> 0x40, then redirect colliding with a response and a pop.
    vt[0] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 1'b0};
    vt[1] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 1'b0};
    vt[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 1'b0};
    vt[3] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b1, 32'h04, 1'b0};
    vt[4] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 1'b1, 32'h08, 1'b1};
    vt[5] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h48, 1'b1, 32'h40, 1'b0};
    vt[6] = '{1'b1, 32'h103, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h4C, 1'b1, 32'h44, 1'b0};
    vt[7] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 1'b0, 32'h00, 1'b0};
    vt[8] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h104, 1'b0, 32'h00, 1'b0};
    vt[9] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0};

    release_reset();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(vt[i].redirect, vt[i].rpc, vt[i].hit, vt[i].taken, vt[i].tgt, vt[i].ifr);
      check($sformatf("vec%0d_req", i), 32'(imem_req_valid), 32'(vt[i].e_req));
      check($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
      check($sformatf("vec%0d_ifv", i), 32'(if_valid), 32'(vt[i].e_ifv));
      check($sformatf("vec%0d_ifpc", i), if_pc, vt[i].e_ifpc);
      check($sformatf("vec%0d_pred", i), 32'(if_pred_taken), 32'(vt[i].e_pred));
      commit();
    end

    // Full queue with decode stalled: exactly DEPTH fires, then in-order drain and resume.
    apply_reset();
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    check("full_fire_cnt", 32'(n_fire), 32'(DEPTH));
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    check("full_stall", 32'(imem_req_valid), 32'h0);
    check("full_pc_hold", imem_addr, 32'h10);
    commit();
    seen = 1'b0;
    first_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      if (if_valid) popped.push_back(if_pc);
      if (last_fire && !seen) begin
        seen = 1'b1;
        first_addr = imem_addr;
      end
      commit();
    end
    check("resume_addr", first_addr, 32'h10);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain%0d", i), (popped.size() > i) ? popped[i] : 32'hFFFF_FFFF,
            32'(4 * i));
    end

    // Slow memory, 3 requests outstanding, redirect to an unaligned PC.
    apply_reset();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("slow_outstanding", 32'(pend.size()), 32'd3);
    step(1'b1, 32'h103, 1'b0, 1'b0, '0, 1'b1);
    seen = 1'b0;
    first_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      if (i == 0) check("redir_first_req", imem_addr, 32'h100);
      if (if_valid) begin
        seen = 1'b1;
        first_addr = if_pc;
      end
      commit();
    end
    check("redir_first_ifpc", first_addr, 32'h100);

    // Asynchronous reset with requests outstanding and queue occupied.
    apply_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    check("pre_rst_outstanding", 32'(pend.size()), 32'd2);
    check("pre_rst_ifv", 32'(if_valid), 32'h1);
    apply_reset();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("post_rst_addr", imem_addr, RESET_PC);
    check("post_rst_req", 32'(imem_req_valid), 32'h1);
    commit();

    // Randomized traffic.
    apply_reset();
    ready_pct = 70; rsp_pct = 75; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(19) == 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      h   = ($urandom_range(3) == 0);
      t   = ($urandom_range(1) == 1);
      f   = ($urandom_range(9) < 6);
      step(r, rpc, h, t, $urandom, f);
    end
`ifdef FETCH_PERF_CNT_EN
    #1;
    check("perf_fetch", perf_fetch_cnt, 32'(n_fire));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
